hyperbus_rwds_calib: RTL and testbench

- Calibration controller that picks the RWDS sampling edge (edge index and polarity) driven into the RWDS sampler's configuration inputs.
- Sweeps every candidate edge code in time order and issues training probe transactions through the PHY.
- Locates the widest contiguous passing window and programs its centre.
- Sits in the PHY clock domain beside the PHY FSM. Software can bypass it with a static override.

---
 rtl/hyperbus_pkg.sv | 44 ++++
 rtl/hyperbus_calib_window.sv | 77 +++++++
 rtl/hyperbus_rwds_calib.sv | 220 ++++++++++++++++++++++
 tb/tb_hyperbus_rwds_calib.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyperbus_pkg.sv
// ---------------------------------------------------------------------------
// hyperbus_pkg
//   Shared types and helpers for the HyperBus PHY blocks.
//   - edge_code_t   : 5-bit RWDS sampling-edge code, time ordered.
//                     Code 0 is the first falling edge, code 1 the next
//                     rising edge, and so on.
//   - calib_state_e : RWDS calibration controller states.
//   - code_to_idx / code_to_pol : split a code into the sampler's edge index
//                     and polarity fields.
//   - window_centre : floor centre of a window given its start and length.
// ---------------------------------------------------------------------------
package hyperbus_pkg;

    localparam int EdgeCodeW = 5;
    localparam int WinLenW   = 6;   // wide enough to hold a length of 32

    typedef logic [EdgeCodeW-1:0] edge_code_t;
    typedef logic [WinLenW-1:0]   win_len_t;

    typedef enum logic [2:0] {
        CS_IDLE       = 3'd0,
        CS_APPLY      = 3'd1,
        CS_PROBE_REQ  = 3'd2,
        CS_PROBE_WAIT = 3'd3,
        CS_EVAL       = 3'd4,
        CS_FINISH     = 3'd5
    } calib_state_e;

    function automatic logic [3:0] code_to_idx(input edge_code_t code);
        return code[4:1];
    endfunction

    function automatic logic code_to_pol(input edge_code_t code);
        return code[0];
    endfunction

    // start + floor((len-1)/2). Only meaningful for len > 0. The sum always
    // fits in a code because the window lies inside the swept code range.
    function automatic edge_code_t window_centre(input edge_code_t start,
                                                 input win_len_t   len);
        return edge_code_t'({1'b0, start} + ((len - win_len_t'(1)) >> 1));
    endfunction

endpackage

// File: rtl/hyperbus_calib_window.sv
// ---------------------------------------------------------------------------
// hyperbus_calib_window
//   Tracks the running window of consecutive passing codes and the best
//   (widest, earliest on ties) window seen during one sweep.
//
//   Ports:
//     clk_i, rst_ni   : clock, synchronous active-low reset
//     clear_i         : drop both trackers (start of a new sweep)
//     eval_valid_i    : one code's result is presented this cycle
//     pass_i          : that code passed all probes
//     code_i          : the code being evaluated
//     last_i          : code_i is the final code of the sweep
//     best_start_o    : start code of the best window
//     best_len_o      : length of the best window, 0 when none
// ---------------------------------------------------------------------------
module hyperbus_calib_window
    import hyperbus_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       eval_valid_i,
    input  logic       pass_i,
    input  edge_code_t code_i,
    input  logic       last_i,
    output edge_code_t best_start_o,
    output win_len_t   best_len_o
);

    edge_code_t r_cur_start;
    win_len_t   r_cur_len;
    edge_code_t r_best_start;
    win_len_t   r_best_len;

    edge_code_t w_cur_start_next;
    win_len_t   w_cur_len_next;
    logic       w_close;
    edge_code_t w_cand_start;
    win_len_t   w_cand_len;

    // A pass extends (or opens) the running window; a fail ends it.
    assign w_cur_start_next = (pass_i && (r_cur_len == '0)) ? code_i : r_cur_start;
    assign w_cur_len_next   = pass_i ? (r_cur_len + win_len_t'(1)) : '0;

    // A window closes on a fail, or at the last code where the window may
    // still be open. On the last code the candidate must include this
    // code's own result, so the post-update values are used when it passed.
    assign w_close      = !pass_i || last_i;
    assign w_cand_start = pass_i ? w_cur_start_next : r_cur_start;
    assign w_cand_len   = pass_i ? w_cur_len_next   : r_cur_len;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cur_start  <= '0;
            r_cur_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
        end else if (clear_i) begin
            r_cur_start  <= '0;
            r_cur_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
        end else if (eval_valid_i) begin
            r_cur_start <= w_cur_start_next;
            r_cur_len   <= w_cur_len_next;
            // Strict compare keeps the earliest window when lengths tie.
            if (w_close && (w_cand_len > r_best_len)) begin
                r_best_start <= w_cand_start;
                r_best_len   <= w_cand_len;
            end
        end
    end

    assign best_start_o = r_best_start;
    assign best_len_o   = r_best_len;

endmodule

// File: rtl/hyperbus_rwds_calib.sv
// ---------------------------------------------------------------------------
// hyperbus_rwds_calib
//   RWDS sampling-edge calibration controller. Sweeps every edge code from 0
//   to MaxCode, issues NumProbes training probes per code through the PHY,
//   finds the widest contiguous passing window and programs its centre into
//   the sampler configuration. Software can force the configuration while
//   the controller is idle.
//
//   Ports:
//     clk_i, rst_ni        : PHY clock, synchronous active-low reset
//     calib_start_i        : pulse, start a sweep (ignored unless idle and
//                            not overridden)
//     sw_override_i        : while idle, cfg outputs follow sw_* inputs
//     sw_edge_idx_i/pol_i  : software edge selection
//     probe_valid_o        : request one training transaction
//     probe_ready_i        : PHY accepts the probe
//     probe_resp_valid_i   : probe finished (one-cycle pulse)
//     probe_pass_i         : probe data matched, qualified by resp_valid
//     cfg_edge_idx_o/pol_o : registered sampler configuration
//     calib_busy_o         : sweep in progress
//     calib_done_o         : one-cycle pulse at the end of a sweep
//     calib_err_o          : no passing code found, sticky until next start
//     win_start_o/len_o    : best window of the last completed sweep
// ---------------------------------------------------------------------------
module hyperbus_rwds_calib
    import hyperbus_pkg::*;
#(
    parameter int         MaxCode       = 31,
    parameter int         NumProbes     = 4,
    parameter int         SettleCycles  = 8,
    parameter int         TimeoutCycles = 255,
    parameter edge_code_t DefaultCode   = 5'd3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       calib_start_i,
    input  logic       sw_override_i,
    input  logic [3:0] sw_edge_idx_i,
    input  logic       sw_edge_pol_i,
    output logic       probe_valid_o,
    input  logic       probe_ready_i,
    input  logic       probe_resp_valid_i,
    input  logic       probe_pass_i,
    output logic [3:0] cfg_edge_idx_o,
    output logic       cfg_edge_pol_o,
    output logic       calib_busy_o,
    output logic       calib_done_o,
    output logic       calib_err_o,
    output logic [4:0] win_start_o,
    output logic [5:0] win_len_o
);

    localparam int SetW = (SettleCycles  > 1) ? $clog2(SettleCycles  + 1) : 1;
    localparam int PrbW = (NumProbes     > 1) ? $clog2(NumProbes     + 1) : 1;
    localparam int TmoW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;

    calib_state_e    r_state;
    edge_code_t      r_code;
    logic [SetW-1:0] r_settle_cnt;
    logic [PrbW-1:0] r_probe_cnt;
    logic [TmoW-1:0] r_tmo_cnt;
    logic            r_eval_pass;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    edge_code_t      r_win_start;
    win_len_t        r_win_len;
    logic [3:0]      r_cfg_idx;
    logic            r_cfg_pol;

    logic            w_start_ok;
    logic            w_eval_valid;
    logic            w_last;
    edge_code_t      w_best_start;
    win_len_t        w_best_len;

    assign w_start_ok   = (r_state == CS_IDLE) && calib_start_i && !sw_override_i;
    assign w_eval_valid = (r_state == CS_EVAL);
    assign w_last       = (r_code == edge_code_t'(MaxCode));

    hyperbus_calib_window u_window (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (w_start_ok),
        .eval_valid_i (w_eval_valid),
        .pass_i       (r_eval_pass),
        .code_i       (r_code),
        .last_i       (w_last),
        .best_start_o (w_best_start),
        .best_len_o   (w_best_len)
    );

    // ------------------------------------------------------------------
    // Sweep sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= CS_IDLE;
            r_code       <= DefaultCode;
            r_settle_cnt <= '0;
            r_probe_cnt  <= '0;
            r_tmo_cnt    <= '0;
            r_eval_pass  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_win_start  <= '0;
            r_win_len    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                CS_IDLE: begin
                    if (w_start_ok) begin
                        r_code       <= '0;
                        r_err        <= 1'b0;
                        r_busy       <= 1'b1;
                        r_settle_cnt <= '0;
                        r_state      <= CS_APPLY;
                    end
                end

                // The sampler treats cfg as pseudostatic, so give the new
                // code time to propagate before the first probe.
                CS_APPLY: begin
                    if (r_settle_cnt == SetW'(SettleCycles - 1)) begin
                        r_probe_cnt <= '0;
                        r_state     <= CS_PROBE_REQ;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + SetW'(1);
                    end
                end

                CS_PROBE_REQ: begin
                    if (probe_ready_i) begin
                        r_tmo_cnt <= '0;
                        r_state   <= CS_PROBE_WAIT;
                    end
                end

                // A response wins over a coincident timeout. The first failing
                // probe decides the code, so the remaining probes are skipped.
                CS_PROBE_WAIT: begin
                    if (probe_resp_valid_i) begin
                        if (!probe_pass_i) begin
                            r_eval_pass <= 1'b0;
                            r_state     <= CS_EVAL;
                        end else if (r_probe_cnt == PrbW'(NumProbes - 1)) begin
                            r_eval_pass <= 1'b1;
                            r_state     <= CS_EVAL;
                        end else begin
                            r_probe_cnt <= r_probe_cnt + PrbW'(1);
                            r_state     <= CS_PROBE_REQ;
                        end
                    end else if (r_tmo_cnt == TmoW'(TimeoutCycles - 1)) begin
                        r_eval_pass <= 1'b0;
                        r_state     <= CS_EVAL;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TmoW'(1);
                    end
                end

                // The window tracker consumes the result this cycle.
                CS_EVAL: begin
                    if (w_last) begin
                        r_state <= CS_FINISH;
                    end else begin
                        r_code       <= r_code + edge_code_t'(1);
                        r_settle_cnt <= '0;
                        r_state      <= CS_APPLY;
                    end
                end

                CS_FINISH: begin
                    r_win_start <= w_best_start;
                    r_win_len   <= w_best_len;
                    if (w_best_len != '0) begin
                        r_code <= window_centre(w_best_start, w_best_len);
                    end else begin
                        r_code <= DefaultCode;
                        r_err  <= 1'b1;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= CS_IDLE;
                end

                default: begin
                    r_state <= CS_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered sampler configuration. Software may only take over while
    // the controller is idle so a sweep is never disturbed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cfg_idx <= code_to_idx(DefaultCode);
            r_cfg_pol <= code_to_pol(DefaultCode);
        end else if (sw_override_i && (r_state == CS_IDLE)) begin
            r_cfg_idx <= sw_edge_idx_i;
            r_cfg_pol <= sw_edge_pol_i;
        end else begin
            r_cfg_idx <= code_to_idx(r_code);
            r_cfg_pol <= code_to_pol(r_code);
        end
    end

    assign probe_valid_o  = (r_state == CS_PROBE_REQ);
    assign cfg_edge_idx_o = r_cfg_idx;
    assign cfg_edge_pol_o = r_cfg_pol;
    assign calib_busy_o   = r_busy;
    assign calib_done_o   = r_done;
    assign calib_err_o    = r_err;
    assign win_start_o    = r_win_start;
    assign win_len_o      = r_win_len;

endmodule

// File: tb/tb_hyperbus_rwds_calib.sv
// ---------------------------------------------------------------------------
// tb_hyperbus_rwds_calib
//   Self-checking bench for hyperbus_rwds_calib. A PHY responder answers
//   probes from per-code tables (first failing probe index, no-response
//   codes, ready stall). Expected windows, centre codes and probe counts are
//   computed directly from those tables.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hyperbus_rwds_calib;

    localparam int MAXC   = 15;
    localparam int NP     = 2;
    localparam int SETTLE = 8;
    localparam int TMO    = 255;
    localparam int DEF    = 3;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       calib_start_i;
    logic       sw_override_i;
    logic [3:0] sw_edge_idx_i;
    logic       sw_edge_pol_i;
    logic       probe_valid_o;
    logic       probe_ready_i;
    logic       probe_resp_valid_i;
    logic       probe_pass_i;
    logic [3:0] cfg_edge_idx_o;
    logic       cfg_edge_pol_o;
    logic       calib_busy_o;
    logic       calib_done_o;
    logic       calib_err_o;
    logic [4:0] win_start_o;
    logic [5:0] win_len_o;

    hyperbus_rwds_calib #(
        .MaxCode       (MAXC),
        .NumProbes     (NP),
        .SettleCycles  (SETTLE),
        .TimeoutCycles (TMO),
        .DefaultCode   (5'(DEF))
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .calib_start_i      (calib_start_i),
        .sw_override_i      (sw_override_i),
        .sw_edge_idx_i      (sw_edge_idx_i),
        .sw_edge_pol_i      (sw_edge_pol_i),
        .probe_valid_o      (probe_valid_o),
        .probe_ready_i      (probe_ready_i),
        .probe_resp_valid_i (probe_resp_valid_i),
        .probe_pass_i       (probe_pass_i),
        .cfg_edge_idx_o     (cfg_edge_idx_o),
        .cfg_edge_pol_o     (cfg_edge_pol_o),
        .calib_busy_o       (calib_busy_o),
        .calib_done_o       (calib_done_o),
        .calib_err_o        (calib_err_o),
        .win_start_o        (win_start_o),
        .win_len_o          (win_len_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Scenario tables written by the main process only.
    int fail_at [0:31];   // index of first failing probe; NP = code passes
    bit noresp  [0:31];   // PHY never answers the first probe of this code
    int stall_req;        // ready held low this many cycles on first probe
    int sweep_id;

    // Logs written by the PHY process only.
    int probes_seen [0:31];
    int hs_cycle    [0:31];
    int stall_bad;
    int stall_seen;

    int cyc = 0;
    int done_total = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge clk_i);
            if (calib_done_o === 1'b1) done_total++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // PHY responder
    // ------------------------------------------------------------------
    initial begin
        int         last_id;
        int         stall_left;
        bit         stall_on;
        logic [4:0] stall_code;
        bit         pend;
        int         pend_dly;
        bit         pend_pass;
        logic [4:0] cur;
        int         k;
        last_id = 0; stall_left = 0; stall_on = 0; stall_code = '0;
        pend = 0; pend_dly = 0; pend_pass = 0;
        probe_ready_i = 1'b0; probe_resp_valid_i = 1'b0; probe_pass_i = 1'b0;
        stall_bad = 0; stall_seen = 0;
        for (int c = 0; c < 32; c++) begin probes_seen[c] = 0; hs_cycle[c] = 0; end
        forever begin
            @(negedge clk_i);
            if (sweep_id != last_id) begin
                last_id = sweep_id;
                for (int c = 0; c < 32; c++) begin probes_seen[c] = 0; hs_cycle[c] = 0; end
                stall_left = stall_req; stall_on = 0; stall_bad = 0; stall_seen = 0;
                pend = 0;
            end
            probe_resp_valid_i = 1'b0;
            probe_pass_i       = 1'b0;
            if (pend) begin
                if (pend_dly == 0) begin
                    probe_resp_valid_i = 1'b1;
                    probe_pass_i       = pend_pass;
                    pend               = 0;
                end else begin
                    pend_dly--;
                end
            end
            cur = {cfg_edge_idx_o, cfg_edge_pol_o};
            if (stall_left > 0 && (probe_valid_o === 1'b1 || stall_on)) begin
                if (!stall_on) stall_code = cur;
                stall_on = 1;
                if (probe_valid_o !== 1'b1 || cur != stall_code) stall_bad++;
                stall_seen++;
                stall_left--;
                probe_ready_i = 1'b0;
            end else if (probe_valid_o === 1'b1) begin
                // Ready goes high now, so the handshake lands on the next edge.
                stall_on      = 0;
                probe_ready_i = 1'b1;
                k = probes_seen[cur];
                probes_seen[cur]++;
                if (k == 0) hs_cycle[cur] = cyc;
                if (!noresp[cur]) begin
                    pend      = 1;
                    pend_dly  = $urandom_range(0, 3);
                    pend_pass = (k < fail_at[cur]);
                end
            end else begin
                probe_ready_i = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // One sweep, checked against a window search over the scenario tables
    // ------------------------------------------------------------------
    task automatic run_sweep(input string tag);
        int bs, bl, run, rs, ec, d0, exp_p;
        bit got, ok;
        bs = 0; bl = 0; run = 0; rs = 0;
        for (int c = 0; c <= MAXC; c++) begin
            ok = !noresp[c] && (fail_at[c] >= NP);
            if (ok) begin
                if (run == 0) rs = c;
                run++;
                if (run > bl) begin bl = run; bs = rs; end
            end else begin
                run = 0;
            end
        end
        ec = (bl > 0) ? bs + (bl - 1) / 2 : DEF;

        sweep_id++;
        @(negedge clk_i);
        d0 = done_total;
        calib_start_i = 1'b1;
        @(negedge clk_i);
        calib_start_i = 1'b0;
        @(negedge clk_i);
        check({tag, "_busy_after_start"}, calib_busy_o, 1);
        check({tag, "_err_cleared"}, calib_err_o, 0);

        got = 0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clk_i);
            if (calib_done_o === 1'b1) got = 1;
        end
        check({tag, "_done_seen"}, int'(got), 1);
        if (got) begin
            check({tag, "_win_start"}, win_start_o, bs);
            check({tag, "_win_len"}, win_len_o, bl);
            check({tag, "_err"}, calib_err_o, (bl == 0) ? 1 : 0);
            check({tag, "_busy_end"}, calib_busy_o, 0);
            @(negedge clk_i);
            check({tag, "_cfg_idx"}, cfg_edge_idx_o, ec >> 1);
            check({tag, "_cfg_pol"}, cfg_edge_pol_o, ec & 1);
            repeat (5) @(negedge clk_i);
            check({tag, "_done_pulses"}, done_total - d0, 1);
            for (int c = 0; c <= MAXC; c++) begin
                if (noresp[c]) exp_p = 1;
                else if (fail_at[c] >= NP) exp_p = NP;
                else exp_p = fail_at[c] + 1;
                check($sformatf("%s_probes_code%0d", tag, c), probes_seen[c], exp_p);
            end
            $display("sweep %s: win_start=%0d win_len=%0d code=%0d (model %0d/%0d/%0d)",
                     tag, win_start_o, win_len_o, {cfg_edge_idx_o, cfg_edge_pol_o}, bs, bl, ec);
        end
    endtask

    task automatic set_pass_range(input int lo, input int hi);
        for (int c = lo; c <= hi; c++) fail_at[c] = NP;
    endtask

    task automatic clear_tables();
        for (int c = 0; c < 32; c++) begin fail_at[c] = 0; noresp[c] = 0; end
        stall_req = 0;
    endtask

    typedef struct {
        bit         ovr;
        logic [3:0] sidx;
        bit         spol;
        bit         start;
        logic [3:0] eidx;
        bit         epol;
        bit         ebusy;
    } vec_t;

    initial begin
        vec_t vecs [6];
        int   d0, gap;
        bit   got;

        vecs[0] = '{ovr: 0, sidx: 4'd0,  spol: 0, start: 0, eidx: 4'd1,  epol: 1, ebusy: 0};
        vecs[1] = '{ovr: 1, sidx: 4'd7,  spol: 0, start: 0, eidx: 4'd7,  epol: 0, ebusy: 0};
        vecs[2] = '{ovr: 1, sidx: 4'd7,  spol: 0, start: 1, eidx: 4'd7,  epol: 0, ebusy: 0};
        vecs[3] = '{ovr: 1, sidx: 4'd15, spol: 1, start: 0, eidx: 4'd15, epol: 1, ebusy: 0};
        vecs[4] = '{ovr: 0, sidx: 4'd9,  spol: 0, start: 0, eidx: 4'd1,  epol: 1, ebusy: 0};
        vecs[5] = '{ovr: 1, sidx: 4'd0,  spol: 0, start: 0, eidx: 4'd0,  epol: 0, ebusy: 0};

        rst_ni = 1'b0; calib_start_i = 1'b0; sw_override_i = 1'b0;
        sw_edge_idx_i = 4'd0; sw_edge_pol_i = 1'b0; sweep_id = 0;
        clear_tables();
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        check("rst_cfg_idx", cfg_edge_idx_o, 1);
        check("rst_cfg_pol", cfg_edge_pol_o, 1);
        check("rst_busy", calib_busy_o, 0);
        check("rst_done", calib_done_o, 0);
        check("rst_err", calib_err_o, 0);
        check("rst_probe_valid", probe_valid_o, 0);
        check("rst_win_start", win_start_o, 0);
        check("rst_win_len", win_len_o, 0);

        // Idle configuration mux vectors.
        for (int i = 0; i < 6; i++) begin
            sw_override_i = vecs[i].ovr;
            sw_edge_idx_i = vecs[i].sidx;
            sw_edge_pol_i = vecs[i].spol;
            calib_start_i = vecs[i].start;
            @(negedge clk_i);
            calib_start_i = 1'b0;
            @(negedge clk_i);
            check($sformatf("vec%0d_cfg_idx", i), cfg_edge_idx_o, vecs[i].eidx);
            check($sformatf("vec%0d_cfg_pol", i), cfg_edge_pol_o, vecs[i].epol);
            check($sformatf("vec%0d_busy", i), calib_busy_o, vecs[i].ebusy);
            $display("vec %0d: ovr=%0d sw=%0d/%0d start=%0d -> cfg=%0d/%0d busy=%0d",
                     i, vecs[i].ovr, vecs[i].sidx, vecs[i].spol, vecs[i].start,
                     cfg_edge_idx_o, cfg_edge_pol_o, calib_busy_o);
        end
        sw_override_i = 1'b0;
        @(negedge clk_i);

        // Single window 4..9.
        clear_tables(); set_pass_range(4, 9);
        run_sweep("win4_9");
        // Tie: earliest window wins.
        clear_tables(); set_pass_range(2, 4); set_pass_range(8, 10);
        run_sweep("tie");
        // Window still open at the last code.
        clear_tables(); set_pass_range(12, 15);
        run_sweep("open_end");
        // Partial failures: second probe fails on some codes.
        clear_tables(); set_pass_range(1, 6); fail_at[3] = 1; set_pass_range(9, 11);
        run_sweep("partial");
        // Nothing passes.
        clear_tables();
        run_sweep("all_fail");
        // Timeout on code 5 plus a ready stall on the first probe.
        clear_tables(); set_pass_range(4, 9); noresp[5] = 1; stall_req = 10;
        run_sweep("timeout");
        gap = hs_cycle[6] - hs_cycle[5];
        check("timeout_gap_in_range", int'(gap >= TMO && gap <= TMO + SETTLE + 4), 1);
        check("stall_cycles", stall_seen, 10);
        check("stall_valid_cfg_held", stall_bad, 0);
        $display("timeout: handshake gap code5->code6 = %0d cycles", gap);

        // Random scenarios.
        for (int r = 0; r < 4; r++) begin
            clear_tables();
            for (int c = 0; c <= MAXC; c++)
                fail_at[c] = ($urandom_range(0, 2) != 0) ? NP : int'($urandom_range(0, NP - 1));
            run_sweep($sformatf("rand%0d", r));
        end

        // Reset asserted while waiting for a probe response.
        clear_tables(); set_pass_range(0, MAXC); noresp[0] = 1;
        sweep_id++;
        @(negedge clk_i);
        calib_start_i = 1'b1;
        @(negedge clk_i);
        calib_start_i = 1'b0;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk_i);
            if (probes_seen[0] > 0) got = 1;
        end
        check("abort_reached_wait", int'(got), 1);
        repeat (3) @(negedge clk_i);
        d0 = done_total;
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("abort_busy", calib_busy_o, 0);
        check("abort_probe_valid", probe_valid_o, 0);
        check("abort_cfg_idx", cfg_edge_idx_o, 1);
        check("abort_cfg_pol", cfg_edge_pol_o, 1);
        rst_ni = 1'b1;
        repeat (300) @(negedge clk_i);
        check("abort_no_done", done_total - d0, 0);
        check("abort_stays_idle", calib_busy_o, 0);
        check("abort_no_probe", probe_valid_o, 0);
        $display("abort: reset during probe wait, done pulses after = %0d", done_total - d0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
